// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates two cores' instruction and data ports onto one RAM port.
// Define ARB_RR_EN for round-robin tie-breaking between cores; default build always favours core 0.
module mem_arbiter #(
  parameter int WORD_W = 32
) (
  input  logic                   CLK,
  input  logic                   n_rst,
  input  logic [1:0]             iREN,
  input  logic [1:0][WORD_W-1:0] iaddr,
  input  logic [1:0]             dREN,
  input  logic [1:0]             dWEN,
  input  logic [1:0][WORD_W-1:0] daddr,
  input  logic [1:0][WORD_W-1:0] dstore,
  output logic [1:0]             iwait,
  output logic [1:0]             dwait,
  output logic [1:0][WORD_W-1:0] iload,
  output logic [1:0][WORD_W-1:0] dload,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [WORD_W-1:0]      ramaddr,
  output logic [WORD_W-1:0]      ramstore,
  input  logic [WORD_W-1:0]      ramload,
  input  logic                   ram_wait
);

  typedef enum logic [2:0] {IDLE, GNT_D0, GNT_D1, GNT_I0, GNT_I1} state_t;

  state_t     state, state_nxt;
  logic [1:0] dact;
  logic       fav;
  logic       held;
  logic       gc;

  assign dact = dREN | dWEN;

`ifdef ARB_RR_EN
  logic ptr;
  // After a core starts a grant, the other core wins the next same-type tie.
  always_ff @(posedge CLK or negedge n_rst) begin
    if (!n_rst)
      ptr <= 1'b0;
    else if (state_nxt != IDLE && state_nxt != state)
      ptr <= (state_nxt == GNT_D0 || state_nxt == GNT_I0);
  end
  assign fav = ptr;
`else
  assign fav = 1'b0;
`endif

  function automatic state_t pick(input logic [1:0] d, input logic [1:0] i, input logic f);
    if (d[f])  return f ? GNT_D1 : GNT_D0;
    if (d[~f]) return f ? GNT_D0 : GNT_D1;
    if (i[f])  return f ? GNT_I1 : GNT_I0;
    if (i[~f]) return f ? GNT_I0 : GNT_I1;
    return IDLE;
  endfunction

  always_ff @(posedge CLK or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // Grant is sticky while the owner stays active so multi-word blocks are never split.
  always_comb begin
    held = 1'b0;
    case (state)
      GNT_D0:  held = dact[0];
      GNT_D1:  held = dact[1];
      GNT_I0:  held = iREN[0];
      GNT_I1:  held = iREN[1];
      default: held = 1'b0;
    endcase
    state_nxt = held ? state : pick(dact, iREN, fav);
  end

  assign gc = (state == GNT_D1) || (state == GNT_I1);

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 2'b11;
    dwait    = 2'b11;
    case (state)
      GNT_D0, GNT_D1: begin
        ramaddr   = daddr[gc];
        ramstore  = dstore[gc];
        ramWEN    = dWEN[gc];
        ramREN    = dREN[gc] & ~dWEN[gc];
        dwait[gc] = ram_wait;
      end
      GNT_I0, GNT_I1: begin
        ramaddr   = iaddr[gc];
        ramREN    = iREN[gc];
        iwait[gc] = ram_wait;
      end
      default: ;
    endcase
  end

  assign iload = {ramload, ramload};
  assign dload = {ramload, ramload};

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic checked every cycle
// against a source-index reference model of the arbiter.
module tb_mem_arbiter;
  localparam int W = 32;

  logic              CLK = 1'b0;
  logic              n_rst;
  logic [1:0]        iREN, dREN, dWEN, iwait, dwait;
  logic [1:0][W-1:0] iaddr, daddr, dstore, iload, dload;
  logic              ramREN, ramWEN, ram_wait;
  logic [W-1:0]      ramaddr, ramstore, ramload;

  int tests = 0;
  int fails = 0;
  // Model: granted source 0=D0 1=D1 2=I0 3=I1, -1 = none.
  int m_gnt = -1;
  int m_ptr = 0;

  always #5 CLK = ~CLK;

  mem_arbiter #(.WORD_W(W)) dut (
    .CLK(CLK), .n_rst(n_rst),
    .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_wait(ram_wait)
  );

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask

  function automatic bit src_act(input int s);
    if (s < 2) return dREN[s] | dWEN[s];
    return iREN[s-2];
  endfunction

  function automatic int pick_src();
    int order[4];
    int f;
    f = 0;
`ifdef ARB_RR_EN
    f = m_ptr;
`endif
    order = '{f, 1 - f, 2 + f, 3 - f};
    for (int k = 0; k < 4; k++)
      if (src_act(order[k])) return order[k];
    return -1;
  endfunction

  always @(posedge CLK or negedge n_rst) begin
    if (!n_rst) begin
      m_gnt = -1;
      m_ptr = 0;
    end else if (m_gnt < 0 || !src_act(m_gnt)) begin
      int nx;
      nx = pick_src();
      if (nx >= 0) m_ptr = 1 - (nx % 2);
      m_gnt = nx;
    end
  end

  always @(negedge CLK) begin : cmp
    logic [W-1:0] ea, es;
    logic         er, ew;
    logic [1:0]   eiw, edw;
    int           c;
    ea = '0; es = '0; er = 1'b0; ew = 1'b0; eiw = 2'b11; edw = 2'b11;
    if (m_gnt >= 0) begin
      c = m_gnt % 2;
      if (m_gnt < 2) begin
        ea = daddr[c]; es = dstore[c]; ew = dWEN[c];
        er = dREN[c] & ~dWEN[c]; edw[c] = ram_wait;
      end else begin
        ea = iaddr[c]; er = iREN[c]; eiw[c] = ram_wait;
      end
    end
    chk("ramREN", ramREN, er);
    chk("ramWEN", ramWEN, ew);
    chk("ramaddr", ramaddr, ea);
    chk("ramstore", ramstore, es);
    chk("iwait", iwait, eiw);
    chk("dwait", dwait, edw);
    chk("iload", iload, {ramload, ramload});
    chk("dload", dload, {ramload, ramload});
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr();
    iREN = '0; dREN = '0; dWEN = '0;
  endtask

  logic [W-1:0] words [4];

  initial begin
    n_rst = 1'b0; clr();
    iaddr = '0; daddr = '0; dstore = '0; ram_wait = 1'b0; ramload = '0;
    tick(); tick();
    #3;
    chk("rst_ramREN", ramREN, 0);
    chk("rst_iwait", iwait, 2'b11);
    chk("rst_dwait", dwait, 2'b11);

    // Single data read: one cycle of arbitration, then forwarded.
    tick();
    n_rst = 1'b1; dREN[0] = 1'b1; daddr[0] = 32'h100; ramload = 32'hCAFE;
    #3 chk("rd_c1_dwait0", dwait[0], 1);
    tick(); #3;
    chk("rd_c2_ramREN", ramREN, 1);
    chk("rd_c2_ramaddr", ramaddr, 32'h100);
    chk("rd_c2_dwait0", dwait[0], 0);
    chk("rd_c2_dload0", dload[0], 32'hCAFE);
    chk("rd_c2_model", m_gnt, 0);

    // Data beats instruction; instruction gets the port with no idle gap.
    clr(); tick();
    dREN[0] = 1'b1; daddr[0] = 32'h300; iREN[1] = 1'b1; iaddr[1] = 32'h400;
    tick(); #3;
    chk("pri_addr_d0", ramaddr, 32'h300);
    chk("pri_iwait1_a", iwait[1], 1);
    tick(); #3;
    chk("pri_iwait1_b", iwait[1], 1);
    dREN[0] = 1'b0;
    tick(); #3;
    chk("pri_addr_i1", ramaddr, 32'h400);
    chk("pri_iwait1_go", iwait[1], 0);

    // Simultaneous read+write is a write.
    clr(); tick();
    dREN[1] = 1'b1; dWEN[1] = 1'b1; dstore[1] = 32'h55; daddr[1] = 32'h500;
    tick(); #3;
    chk("wr_ramWEN", ramWEN, 1);
    chk("wr_ramREN", ramREN, 0);
    chk("wr_ramstore", ramstore, 32'h55);

    // Reset in the middle of a stalled access.
    ram_wait = 1'b1;
    #1 n_rst = 1'b0;
    #1;
    chk("arst_dwait", dwait, 2'b11);
    chk("arst_iwait", iwait, 2'b11);
    chk("arst_strobes", {ramREN, ramWEN}, 2'b00);
    chk("arst_model", m_gnt, -1);
    tick();
    n_rst = 1'b1; clr(); ram_wait = 1'b0;
    tick();

    // Core 0 writeback then fill, core 1 waiting throughout.
    words = '{32'h208, 32'h20C, 32'h100, 32'h104};
    dREN[1] = 1'b1; daddr[1] = 32'h600;
    dWEN[0] = 1'b1; daddr[0] = words[0]; dstore[0] = 32'hA5; ram_wait = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      daddr[0] = words[k]; dWEN[0] = (k < 2); dREN[0] = (k >= 2); ram_wait = 1'b1;
      #3 chk("blk_stall", dwait, 2'b11);
      tick();
      ram_wait = 1'b0;
      #3;
      chk("blk_done_d0", dwait[0], 0);
      chk("blk_hold_d1", dwait[1], 1);
      chk("blk_addr", ramaddr, words[k]);
      tick();
    end
    dREN[0] = 1'b0; dWEN[0] = 1'b0;
    tick(); #3;
    chk("blk_d1_addr", ramaddr, 32'h600);
    chk("blk_d1_go", dwait[1], 0);

    // Randomized traffic with occasional asynchronous resets.
    clr(); tick();
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < 2; c++) begin
        if ($urandom_range(3) == 0) iREN[c] = ~iREN[c];
        if ($urandom_range(3) == 0) dREN[c] = ~dREN[c];
        if ($urandom_range(5) == 0) dWEN[c] = ~dWEN[c];
        if ($urandom_range(1) == 0) iaddr[c] = $urandom;
        if ($urandom_range(1) == 0) daddr[c] = $urandom;
        if ($urandom_range(1) == 0) dstore[c] = $urandom;
      end
      ram_wait = 1'($urandom_range(1));
      ramload = $urandom;
      n_rst = ($urandom_range(199) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
